// File: rtl/mem_align_unit.sv
// mem_align_unit: load/store front end between the MEM stage and a
// byte-addressable data memory. Aligned accesses pass straight through in the
// request cycle; misaligned halfword/word accesses are split into single-byte
// accesses while the pipeline is stalled, and load bytes are reassembled and
// sign/zero-extended.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/read/write/func3      MEM stage request (RV32I funct3)
//   req_addr, req_wdata             request byte address and store data
//   stall                           hold the MEM stage
//   rdata, rdata_valid              extended load result and its strobe
//   mem_read/write/func3/addr/wdata access presented to the data memory
//   mem_rdata                       combinational read data from memory
module mem_align_unit #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_func3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned FW   = 3;
    localparam int unsigned ASMW = 24;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [FW-1:0] F3_SB  = 3'b000;
    localparam logic [FW-1:0] F3_H   = 3'b001;
    localparam logic [FW-1:0] F3_W   = 3'b010;
    localparam logic [FW-1:0] F3_LBU = 3'b100;
    localparam logic [FW-1:0] F3_HU  = 3'b101;

    logic [0:0]      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [FW-1:0]   func3_q, func3_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [ASMW-1:0] asm_q, asm_d;

    logic            stall_c;
    logic [DW-1:0]   rdata_c;
    logic            rdata_valid_c;
    logic            mem_read_c;
    logic            mem_write_c;
    logic [FW-1:0]   mem_func3_c;
    logic [AW-1:0]   mem_addr_c;
    logic [DW-1:0]   mem_wdata_c;

    // Both read and write high is treated as a write.
    logic            req_rd;
    logic            req_wr;
    logic            req_mis;
    logic [1:0]      last_idx;
    logic [7:0]      wbyte;
    logic [15:0]     half;

    // Misalignment of the incoming request.
    always_comb begin
        req_rd  = req_read & ~req_write;
        req_wr  = req_write;
        req_mis = 1'b0;
        if ((req_func3 == F3_H) || (req_func3 == F3_HU)) begin
            req_mis = req_addr[0];
        end else if (req_func3 == F3_W) begin
            req_mis = (req_addr[1:0] != 2'b00);
        end
    end

    // Byte of latched store data selected by idx.
    always_comb begin
        wbyte = wdata_q[7:0];
        case (idx_q)
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            2'd3:    wbyte = wdata_q[31:24];
            default: wbyte = wdata_q[7:0];
        endcase
    end

    // Next state and combinational outputs.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        func3_d       = func3_q;
        wdata_d       = wdata_q;
        rd_d          = rd_q;
        wr_d          = wr_q;
        asm_d         = asm_q;
        stall_c       = 1'b0;
        rdata_c       = '0;
        rdata_valid_c = 1'b0;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        mem_func3_c   = '0;
        mem_addr_c    = '0;
        mem_wdata_c   = '0;
        last_idx      = (func3_q == F3_W) ? 2'd3 : 2'd1;
        half          = {mem_rdata[7:0], asm_q[7:0]};

        case (state_q)
            S_IDLE: begin
                mem_read_c    = req_valid & req_rd;
                mem_write_c   = req_valid & req_wr;
                mem_func3_c   = req_func3;
                mem_addr_c    = req_addr;
                mem_wdata_c   = req_wdata;
                rdata_c       = mem_rdata;
                rdata_valid_c = req_valid & req_rd;
                if (SPLIT_EN && req_valid && req_mis && (req_rd || req_wr)) begin
                    // Issue byte 0 now and latch the request for the rest.
                    mem_func3_c   = req_rd ? F3_LBU : F3_SB;
                    mem_wdata_c   = {24'h0, req_wdata[7:0]};
                    rdata_c       = '0;
                    rdata_valid_c = 1'b0;
                    stall_c       = 1'b1;
                    addr_d        = req_addr;
                    func3_d       = req_func3;
                    wdata_d       = req_wdata;
                    rd_d          = req_rd;
                    wr_d          = req_wr;
                    idx_d         = 2'd1;
                    asm_d         = req_rd ? {16'h0, mem_rdata[7:0]} : '0;
                    state_d       = S_BUSY;
                end
            end
            S_BUSY: begin
                mem_read_c  = rd_q;
                mem_write_c = wr_q;
                mem_func3_c = rd_q ? F3_LBU : F3_SB;
                mem_addr_c  = addr_q + AW'(idx_q);
                mem_wdata_c = {24'h0, wbyte};
                if (idx_q != last_idx) begin
                    stall_c = 1'b1;
                    idx_d   = idx_q + 2'd1;
                    if (rd_q) begin
                        case (idx_q)
                            2'd1:    asm_d[15:8]  = mem_rdata[7:0];
                            2'd2:    asm_d[23:16] = mem_rdata[7:0];
                            default: asm_d[7:0]   = mem_rdata[7:0];
                        endcase
                    end
                end else begin
                    // Final byte: assemble, extend, and release the pipeline.
                    rdata_valid_c = rd_q;
                    if (func3_q == F3_W) begin
                        rdata_c = {mem_rdata[7:0], asm_q};
                    end else if (func3_q == F3_HU) begin
                        rdata_c = {16'h0, half};
                    end else begin
                        rdata_c = {{16{half[15]}}, half};
                    end
                    if (!rd_q) begin
                        rdata_c = '0;
                    end
                    idx_d   = 2'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // State and latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            addr_q  <= '0;
            func3_q <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            func3_q <= func3_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            asm_q   <= asm_d;
        end
    end

    // All outputs are forced low while reset is asserted.
    assign stall       = rst ? 1'b0 : stall_c;
    assign rdata       = rst ? '0   : rdata_c;
    assign rdata_valid = rst ? 1'b0 : rdata_valid_c;
    assign mem_read    = rst ? 1'b0 : mem_read_c;
    assign mem_write   = rst ? 1'b0 : mem_write_c;
    assign mem_func3   = rst ? '0   : mem_func3_c;
    assign mem_addr    = rst ? '0   : mem_addr_c;
    assign mem_wdata   = rst ? '0   : mem_wdata_c;

endmodule

// File: tb/tb_mem_align_unit.sv
// Bench for mem_align_unit: a byte memory attached to the unit, a reference
// memory updated from the architectural meaning of each access, directed
// scenarios and a randomized sequence of back-to-back accesses.
module tb_mem_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_read, req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rdata_valid, mem_read, mem_write;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_func3;
    logic        ns_stall, ns_rdata_valid, ns_mem_read, ns_mem_write;
    logic [31:0] ns_rdata, ns_mem_addr, ns_mem_wdata, ns_mem_rdata;
    logic [2:0]  ns_mem_func3;

    logic [7:0]  sim_mem [64];
    logic [7:0]  ref_mem [64];
    logic        tb_load;
    logic [31:0] addr_log [16];
    logic        rd_log [16];
    logic        wr_log [16];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mem_align_unit #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read),
        .req_write(req_write), .req_func3(req_func3), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .mem_read(mem_read), .mem_write(mem_write),
        .mem_func3(mem_func3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_align_unit #(.SPLIT_EN(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read),
        .req_write(req_write), .req_func3(req_func3), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(ns_stall), .rdata(ns_rdata),
        .rdata_valid(ns_rdata_valid), .mem_read(ns_mem_read),
        .mem_write(ns_mem_write), .mem_func3(ns_mem_func3),
        .mem_addr(ns_mem_addr), .mem_wdata(ns_mem_wdata),
        .mem_rdata(ns_mem_rdata)
    );

    // Memory read with RV32I sizing/extension, wrapping on a 64-byte array.
    function automatic logic [31:0] env_read(input logic [31:0] a, input logic [2:0] f3);
        logic [7:0] b0, b1, b2, b3;
        b0 = sim_mem[a[5:0]];
        b1 = sim_mem[6'(a + 32'd1)];
        b2 = sim_mem[6'(a + 32'd2)];
        b3 = sim_mem[6'(a + 32'd3)];
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    always_comb mem_rdata = env_read(mem_addr, mem_func3);
    always_comb ns_mem_rdata = env_read(ns_mem_addr, ns_mem_func3);

    // Memory updates on each rising edge with mem_write high.
    always @(posedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < 64; i++) sim_mem[i] <= ref_mem[i];
        end else if (mem_write) begin
            case (mem_func3)
                3'b000: sim_mem[mem_addr[5:0]] <= mem_wdata[7:0];
                3'b001: begin
                    sim_mem[mem_addr[5:0]]        <= mem_wdata[7:0];
                    sim_mem[6'(mem_addr + 32'd1)] <= mem_wdata[15:8];
                end
                3'b010: begin
                    sim_mem[mem_addr[5:0]]        <= mem_wdata[7:0];
                    sim_mem[6'(mem_addr + 32'd1)] <= mem_wdata[15:8];
                    sim_mem[6'(mem_addr + 32'd2)] <= mem_wdata[23:16];
                    sim_mem[6'(mem_addr + 32'd3)] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit is_mis(input logic [31:0] a, input logic [2:0] f3);
        int sz;
        sz = acc_size(f3);
        return (sz > 1) && ((a % 32'(sz)) != 32'd0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        int sz;
        sz = acc_size(f3);
        v = 32'd0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[6'(a + 32'(i))]) << (8 * i));
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] t;
        for (int i = 0; i < acc_size(f3); i++) begin
            t = wd >> (8 * i);
            ref_mem[6'(a + 32'(i))] = t[7:0];
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic load_mem();
        tb_load = 1'b1;
        @(posedge clk); #1;
        tb_load = 1'b0;
    endtask

    // Presents one request and holds it until stall drops (bounded).
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int cyc, output int stalls,
                             output logic [31:0] res, output int vcount);
        bit done;
        req_valid = 1'b1; req_read = rd; req_write = wr;
        req_func3 = f3; req_addr = a; req_wdata = wd;
        cyc = 0; stalls = 0; vcount = 0; res = 32'd0; done = 0;
        while (!done && cyc < 16) begin
            @(negedge clk);
            addr_log[cyc] = mem_addr;
            rd_log[cyc] = mem_read;
            wr_log[cyc] = mem_write;
            cyc++;
            if (stall) stalls++;
            if (rdata_valid) begin vcount++; res = rdata; end
            if (!stall) done = 1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
        req_func3 = 3'b010; req_addr = 32'd8; req_wdata = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if ({stall, rdata, rdata_valid, mem_read, mem_write, mem_func3, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b rdata=%h rv=%b rd=%b wr=%b f3=%b addr=%h wd=%h required all zero",
                     stall, rdata, rdata_valid, mem_read, mem_write, mem_func3, mem_addr, mem_wdata);
        end
        n_checks++;
        if ({ns_stall, ns_rdata, ns_rdata_valid, ns_mem_read, ns_mem_func3, ns_mem_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_nosplit: got rdata=%h addr=%h required zero", ns_rdata, ns_mem_addr);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_read = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({stall, rdata_valid, mem_read, mem_write} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_idle: got stall=%b rv=%b rd=%b wr=%b required 0000",
                     stall, rdata_valid, mem_read, mem_write);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_aligned_lw();
        int cyc, st, vc;
        logic [31:0] res;
        do_access(1'b1, 1'b0, 3'b010, 32'd8, 32'd0, cyc, st, res, vc);
        n_checks++;
        if (cyc != 1 || st != 0 || vc != 1 || addr_log[0] !== 32'd8) begin
            n_fail++;
            $display("FAIL aligned_lw_timing: got cycles=%0d stalls=%0d valids=%0d addr=%h required 1 0 1 00000008",
                     cyc, st, vc, addr_log[0]);
        end
        n_checks++;
        if (res !== 32'h0000_0019) begin
            n_fail++;
            $display("FAIL aligned_lw_data: got %h required 00000019", res);
        end
    endtask

    task automatic test_misaligned_lw();
        int cyc, st, vc;
        logic [31:0] res;
        do_access(1'b1, 1'b0, 3'b010, 32'd1, 32'd0, cyc, st, res, vc);
        n_checks++;
        if (cyc != 4 || st != 3 || vc != 1) begin
            n_fail++;
            $display("FAIL misaligned_lw_timing: got cycles=%0d stalls=%0d valids=%0d required 4 3 1", cyc, st, vc);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (addr_log[i] !== 32'(i + 1)) begin
                n_fail++;
                $display("FAIL misaligned_lw_addr%0d: got %h required %h", i, addr_log[i], 32'(i + 1));
            end
        end
        n_checks++;
        if (res !== 32'h0900_0000) begin
            n_fail++;
            $display("FAIL misaligned_lw_data: got %h required 09000000", res);
        end
    endtask

    task automatic test_store_load();
        int cyc, st, vc;
        logic [31:0] res;
        logic [31:0] addrs [3];
        logic [2:0]  f3s [3];
        addrs = '{32'd7, 32'd6, 32'd6};
        f3s   = '{3'b001, 3'b001, 3'b101};
        do_access(1'b0, 1'b1, 3'b010, 32'd5, 32'hDEAD_BEEF, cyc, st, res, vc);
        ref_store(32'd5, 3'b010, 32'hDEAD_BEEF);
        n_checks++;
        if (cyc != 4 || st != 3 || vc != 0) begin
            n_fail++;
            $display("FAIL sw5_timing: got cycles=%0d stalls=%0d valids=%0d required 4 3 0", cyc, st, vc);
        end
        do_access(1'b1, 1'b0, 3'b010, 32'd5, 32'd0, cyc, st, res, vc);
        n_checks++;
        if (res !== 32'hDEAD_BEEF || cyc != 4 || vc != 1) begin
            n_fail++;
            $display("FAIL lw5_after_sw: got %h cycles=%0d required deadbeef 4", res, cyc);
        end
        for (int i = 0; i < 3; i++) begin
            do_access(1'b1, 1'b0, f3s[i], addrs[i], 32'd0, cyc, st, res, vc);
            n_checks++;
            if (res !== ref_load(addrs[i], f3s[i]) || cyc != (is_mis(addrs[i], f3s[i]) ? 2 : 1) || vc != 1) begin
                n_fail++;
                $display("FAIL half_load%0d: got %h cycles=%0d required %h %0d", i, res, cyc,
                         ref_load(addrs[i], f3s[i]), is_mis(addrs[i], f3s[i]) ? 2 : 1);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        int cyc, st, vc;
        logic [31:0] res;
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
        req_func3 = 3'b010; req_addr = 32'd1; req_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1 || mem_addr !== 32'd1 || mem_write !== 1'b1 || mem_wdata[7:0] !== 8'hDD) begin
            n_fail++;
            $display("FAIL rstbusy_byte0: got stall=%b addr=%h wr=%b wd=%h required 1 1 1 dd",
                     stall, mem_addr, mem_write, mem_wdata[7:0]);
        end
        @(posedge clk); #1;
        ref_mem[1] = 8'hDD;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({stall, mem_write, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL rstbusy_forced: got stall=%b wr=%b addr=%h required zero", stall, mem_write, mem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL rstbusy_idle: got stall=%b wr=%b required 0 0", stall, mem_write);
        end
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 3'b010, 32'd0, 32'd0, cyc, st, res, vc);
        n_checks++;
        if (res !== ref_load(32'd0, 3'b010) || res[23:8] !== 16'h00DD) begin
            n_fail++;
            $display("FAIL rstbusy_mem: got %h required %h", res, ref_load(32'd0, 3'b010));
        end
    endtask

    task automatic test_split_disabled();
        int n;
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
        req_func3 = 3'b010; req_addr = 32'd1; req_wdata = 32'd0;
        @(negedge clk);
        n_checks++;
        if (ns_stall !== 1'b0 || ns_mem_func3 !== 3'b010 || ns_mem_addr !== 32'd1 ||
            ns_mem_read !== 1'b1 || ns_rdata_valid !== 1'b1 || ns_rdata !== ref_load(32'd1, 3'b010)) begin
            n_fail++;
            $display("FAIL nosplit_lw1: got stall=%b f3=%b addr=%h rv=%b rdata=%h required 0 010 1 1 %h",
                     ns_stall, ns_mem_func3, ns_mem_addr, ns_rdata_valid, ns_rdata, ref_load(32'd1, 3'b010));
        end
        n = 0;
        while (stall && n < 8) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n != 3) begin
            n_fail++;
            $display("FAIL nosplit_companion_busy: got %0d extra cycles required 3", n);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_read = 1'b0;
    endtask

    task automatic test_illegal_rw();
        int cyc, st, vc;
        logic [31:0] res;
        do_access(1'b1, 1'b1, 3'b010, 32'd12, 32'h0102_0304, cyc, st, res, vc);
        ref_store(32'd12, 3'b010, 32'h0102_0304);
        n_checks++;
        if (rd_log[0] !== 1'b0 || wr_log[0] !== 1'b1 || cyc != 1) begin
            n_fail++;
            $display("FAIL illegal_aligned: got rd=%b wr=%b cycles=%0d required 0 1 1", rd_log[0], wr_log[0], cyc);
        end
        do_access(1'b1, 1'b1, 3'b001, 32'd17, 32'h0000_A55A, cyc, st, res, vc);
        ref_store(32'd17, 3'b001, 32'h0000_A55A);
        n_checks++;
        if (rd_log[0] !== 1'b0 || rd_log[1] !== 1'b0 || wr_log[1] !== 1'b1 || cyc != 2 || vc != 0) begin
            n_fail++;
            $display("FAIL illegal_split: got rd=%b%b wr=%b cycles=%0d valids=%0d required 00 1 2 0",
                     rd_log[0], rd_log[1], wr_log[1], cyc, vc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, st, vc;
        logic [31:0] res;
        logic [2:0] ld_f3 [5];
        logic [31:0] a, wd;
        logic [2:0] f3;
        bit rd;
        int exp_cyc, bad;
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int it = 0; it < 80; it++) begin
            rd = 1'($urandom_range(0, 1));
            f3 = rd ? ld_f3[$urandom_range(0, 4)] : ld_f3[$urandom_range(0, 2)];
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'b00;
            wd = $urandom;
            exp_cyc = is_mis(a, f3) ? acc_size(f3) : 1;
            do_access(rd, !rd, f3, a, wd, cyc, st, res, vc);
            n_checks++;
            if (cyc != exp_cyc || st != exp_cyc - 1 || vc != (rd ? 1 : 0)) begin
                n_fail++;
                $display("FAIL rand%0d_timing: got cycles=%0d stalls=%0d valids=%0d required %0d %0d %0d",
                         it, cyc, st, vc, exp_cyc, exp_cyc - 1, rd ? 1 : 0);
            end
            if (exp_cyc > 1) begin
                bad = 0;
                for (int i = 0; i < exp_cyc; i++) if (addr_log[i] !== a + 32'(i)) bad++;
                n_checks++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL rand%0d_addrs: got first %h last %h required base %h", it,
                             addr_log[0], addr_log[exp_cyc - 1], a);
                end
            end
            if (rd) begin
                n_checks++;
                if (res !== ref_load(a, f3)) begin
                    n_fail++;
                    $display("FAIL rand%0d_load f3=%b addr=%h: got %h required %h", it, f3, a, res, ref_load(a, f3));
                end
            end else begin
                ref_store(a, f3, wd);
            end
        end
        bad = 0;
        for (int i = 0; i < 64; i++) if (sim_mem[i] !== ref_mem[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL final_memory: got %0d differing bytes required 0", bad);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tb_load = 1'b0;
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_func3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        ref_mem[0] = 8'h11; ref_mem[4] = 8'h09; ref_mem[8] = 8'h19;
        @(posedge clk); #1;
        load_mem();
        test_reset();
        test_aligned_lw();
        test_misaligned_lw();
        test_split_disabled();
        test_store_load();
        test_reset_mid_busy();
        test_illegal_rw();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
